dma_copy_engine: RTL and testbench
==================================

// Module: dma_copy_engine
// PURPOSE
//  DMA initiator: copies a block of 16-bit words from cfg_src to cfg_dst over the openMSP430 DMA port.
//  Its dma_en/dma_addr outputs are the bus the DMA access monitor watches.
//  That monitor's kill output drives abort, which terminates any in-flight copy.
//  Used by test firmware and peripherals to move data between RAM regions.
// PARAMETERS
//  LEN_W   8   width of the word-count field; max copy = 2**LEN_W-1 words
// PORTS
//  clk         in   1      system clock; all logic on rising edge
//  reset_n     in   1      synchronous, active-low reset
//  cfg_src     in   16     source byte address; bit0 ignored (word aligned)
//  cfg_dst     in   16     destination byte address; bit0 ignored
//  cfg_len     in   LEN_W  words to copy; 0 = empty job
//  start       in   1      job request; sampled only in IDLE
//  abort       in   1      kill from access monitor; terminates job
//  dma_en      out  1      DMA access request
//  dma_we      out  2      2'b00 = read, 2'b11 = word write
//  dma_addr    out  16     DMA byte address; bit0 always 0
//  dma_din     out  16     write data to memory
//  dma_dout    in   16     read data; valid the cycle after read accept
//  dma_ready   in   1      access accepted this cycle
//  dma_resp    in   1      error response; qualifies dma_ready
//  busy        out  1      job in progress (state != IDLE)
//  done        out  1      one-cycle pulse on successful completion
//  err         out  1      sticky; set by abort/dma_resp, cleared on accepted start
//  words_left  out  LEN_W  remaining words in the job
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset (reset_n=0 at edge): state IDLE; all outputs 0; internal src/dst/count/data regs 0.
//  - States: IDLE, RD, RD_CAP, WR, FIN.
//  - IDLE:
//    * start=1, cfg_len!=0 -> RD; latch src/dst (bit0 cleared); words_left=cfg_len; err=0.
//    * start=1, cfg_len==0 -> FIN; err=0; no bus access.
//  - RD: dma_en=1, we=00, addr=src.
//    * ready&!resp -> RD_CAP.
//    * Otherwise hold all bus outputs stable until ready.
//  - RD_CAP: dma_en=0; buf<=dma_dout -> WR.
//  - WR: dma_en=1, we=11, addr=dst, din=buf; hold until ready. On ready&!resp:
//    * src += 2; dst += 2; words_left -= 1.
//    * words_left was 1 -> FIN, else -> RD.
//  - FIN: done=1 for exactly one cycle; dma_en=0 -> IDLE.
//  - Min latency 3 cycles/word (ready on first request cycle); N-word job: done 3N+1 cycles after start.
//  - Address arithmetic mod 2**16: 16'hFFFE + 2 wraps to 16'h0000; no error raised.
//  - dma_resp=1 with ready in RD/WR -> IDLE next cycle; err=1; done not pulsed; no counter update.
//  - abort=1 in any non-IDLE state -> IDLE next cycle.
//    * dma_en=0; err=1; done=0; words_left frozen at current value.
//    * Abort outranks a simultaneous ready/resp: that beat is not counted.
//    * Abort in IDLE: no effect.
//  - start while busy: ignored, config not re-latched.
//  - start and abort in the same IDLE cycle: abort wins; job not started.
//  - reset_n=0 mid-job dominates everything; no done pulse.
// TESTING
//  - src=16'h0200, dst=16'h0400, len=3, ready held high -> reads 0200,0202,0204 and writes 0400,0402,0404 in order; done 10 cycles after start; err=0.
//  - ready held low 4 cycles in first RD -> dma_en/we/addr stable for all 5 cycles; data copied correctly.
//  - len=2, abort asserted in first WR cycle together with ready -> dma_en=0 next cycle; err=1; words_left=2; no done.
//  - src=16'hFFFE, len=2 -> second read at 16'h0000; job completes normally.
//  - dma_resp=1 on first read -> IDLE; err=1; subsequent start with len=1 clears err and completes.
//  - len=0 start -> done one cycle later; dma_en never asserted. Start during busy -> ignored.

Source files
------------

// File: rtl/dma_copy_if.sv
// dma_copy_if: openMSP430-style DMA port shared by the copy engine (master)
// and the memory / bus fabric (slave).
//   dma_en    master->slave  access request
//   dma_we    master->slave  2'b00 read, 2'b11 word write
//   dma_addr  master->slave  byte address, bit0 always 0
//   dma_din   master->slave  write data
//   dma_dout  slave->master  read data, valid the cycle after read accept
//   dma_ready slave->master  access accepted this cycle
//   dma_resp  slave->master  error response, qualifies dma_ready
interface dma_copy_if;
    logic        dma_en;
    logic [1:0]  dma_we;
    logic [15:0] dma_addr;
    logic [15:0] dma_din;
    logic [15:0] dma_dout;
    logic        dma_ready;
    logic        dma_resp;

    modport master (
        output dma_en, dma_we, dma_addr, dma_din,
        input  dma_dout, dma_ready, dma_resp
    );

    modport slave (
        input  dma_en, dma_we, dma_addr, dma_din,
        output dma_dout, dma_ready, dma_resp
    );
endinterface

// File: rtl/dma_copy_engine.sv
// dma_copy_engine: copies cfg_len 16-bit words from cfg_src to cfg_dst over
// the DMA port, one read followed by one write per word.
//   clk, reset_n           clock, synchronous active-low reset
//   cfg_src/cfg_dst/cfg_len job configuration, latched on accepted start
//   start, abort           job request / kill from the access monitor
//   bus (master)           DMA port
//   busy, done, err        status: in job, completion pulse, sticky error
//   words_left             remaining words in the job
//
// state  | meaning
// IDLE   | waiting for start
// RD     | read request at src held until ready
// RD_CAP | capture read data from dma_dout
// WR     | write request of captured word at dst held until ready
// FIN    | successful end, done pulses on the way back to IDLE
module dma_copy_engine #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [15:0]      cfg_src,
    input  logic [15:0]      cfg_dst,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             start,
    input  logic             abort,
    dma_copy_if.master       bus,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [LEN_W-1:0] words_left
);

    typedef enum logic [2:0] {IDLE, RD, RD_CAP, WR, FIN} state_t;

    state_t           state, state_nxt;
    logic [15:0]      src, src_nxt, dst, dst_nxt;
    logic [15:0]      data_buf, buf_nxt;
    logic [LEN_W-1:0] cnt_nxt;
    logic             err_nxt, done_nxt;
    logic             accept, bus_err;

    assign accept  = bus.dma_ready & ~bus.dma_resp;
    assign bus_err = bus.dma_ready &  bus.dma_resp;

    always_comb begin
        state_nxt = state;
        src_nxt   = src;
        dst_nxt   = dst;
        cnt_nxt   = words_left;
        buf_nxt   = data_buf;
        err_nxt   = err;
        done_nxt  = 1'b0;
        // abort outranks any handshake on the same cycle, so that beat is lost
        if (state != IDLE && abort) begin
            state_nxt = IDLE;
            err_nxt   = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        err_nxt   = 1'b0;
                        cnt_nxt   = cfg_len;
                        src_nxt   = {cfg_src[15:1], 1'b0};
                        dst_nxt   = {cfg_dst[15:1], 1'b0};
                        state_nxt = (cfg_len != '0) ? RD : FIN;
                    end
                end
                RD: begin
                    if (bus_err) begin
                        state_nxt = IDLE;
                        err_nxt   = 1'b1;
                    end else if (accept) begin
                        state_nxt = RD_CAP;
                    end
                end
                RD_CAP: begin
                    buf_nxt   = bus.dma_dout;
                    state_nxt = WR;
                end
                WR: begin
                    if (bus_err) begin
                        state_nxt = IDLE;
                        err_nxt   = 1'b1;
                    end else if (accept) begin
                        src_nxt   = src + 16'd2;
                        dst_nxt   = dst + 16'd2;
                        cnt_nxt   = words_left - 1'b1;
                        state_nxt = (words_left == LEN_W'(1)) ? FIN : RD;
                    end
                end
                FIN: begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Bus outputs are registered from the next-state view so they line up
    // with the state they belong to and stay stable while waiting for ready.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            src          <= '0;
            dst          <= '0;
            data_buf     <= '0;
            words_left   <= '0;
            err          <= 1'b0;
            done         <= 1'b0;
            busy         <= 1'b0;
            bus.dma_en   <= 1'b0;
            bus.dma_we   <= 2'b00;
            bus.dma_addr <= '0;
            bus.dma_din  <= '0;
        end else begin
            state        <= state_nxt;
            src          <= src_nxt;
            dst          <= dst_nxt;
            data_buf     <= buf_nxt;
            words_left   <= cnt_nxt;
            err          <= err_nxt;
            done         <= done_nxt;
            busy         <= (state_nxt != IDLE);
            bus.dma_en   <= (state_nxt == RD) || (state_nxt == WR);
            bus.dma_we   <= (state_nxt == WR) ? 2'b11 : 2'b00;
            bus.dma_addr <= (state_nxt == WR) ? dst_nxt : src_nxt;
            bus.dma_din  <= buf_nxt;
        end
    end

endmodule

// File: tb/tb_dma_copy_engine.sv
// tb_dma_copy_engine: scoreboard bench for dma_copy_engine. A memory model
// answers the DMA port with read data derived from the address; expected
// bus beats are queued when a job is issued and popped on each accepted beat.
module tb_dma_copy_engine;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] cfg_src, cfg_dst;
    logic [7:0]  cfg_len;
    logic        start, abort;
    logic        busy, done, err;
    logic [7:0]  words_left;

    always #5 clk = ~clk;

    dma_copy_if bus ();

    dma_copy_engine #(.LEN_W(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cfg_src    (cfg_src),
        .cfg_dst    (cfg_dst),
        .cfg_len    (cfg_len),
        .start      (start),
        .abort      (abort),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .words_left (words_left)
    );

    int errors = 0;
    int checks = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] pat(input logic [15:0] a);
        return a ^ 16'hA5C3;
    endfunction

    typedef struct packed {
        logic [1:0]  we;
        logic [15:0] addr;
        logic [15:0] data;
    } beat_t;

    beat_t exp_q[$];
    logic  sb_en = 1'b1;

    int   cyc = 0;
    int   done_cnt = 0, done_cyc = 0, en_cnt = 0, wait_cnt = 0;
    logic auto_ready = 1'b1;
    int   stall = 0;
    logic resp_once = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // slave handshake, driven just after the active edge
    initial begin
        bus.dma_ready = 1'b0;
        bus.dma_resp  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.dma_en && auto_ready && stall == 0) begin
                bus.dma_ready = 1'b1;
                bus.dma_resp  = resp_once;
                resp_once     = 1'b0;
            end else begin
                bus.dma_ready = 1'b0;
                bus.dma_resp  = 1'b0;
                if (bus.dma_en && stall > 0) stall--;
            end
        end
    end

    always @(posedge clk)
        if (bus.dma_en && bus.dma_ready && !bus.dma_resp && bus.dma_we == 2'b00)
            bus.dma_dout <= pat(bus.dma_addr);

    logic        prev_wait = 1'b0;
    logic [15:0] prev_addr, prev_din;
    logic [1:0]  prev_we;

    always @(negedge clk) begin
        beat_t e;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bus.dma_en) begin
            en_cnt++;
            if (prev_wait) begin
                check_val("hold_addr", bus.dma_addr, prev_addr);
                check_val("hold_we", bus.dma_we, prev_we);
                check_val("hold_din", bus.dma_din, prev_din);
            end
            prev_wait = !bus.dma_ready;
            prev_addr = bus.dma_addr;
            prev_we   = bus.dma_we;
            prev_din  = bus.dma_din;
            if (!bus.dma_ready) wait_cnt++;
            if (bus.dma_ready && !bus.dma_resp && !abort && sb_en) begin
                if (exp_q.size() == 0) begin
                    check_val("sb_extra_beat", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check_val("beat_we", bus.dma_we, e.we);
                    check_val("beat_addr", bus.dma_addr, e.addr);
                    if (e.we == 2'b11) check_val("beat_data", bus.dma_din, e.data);
                end
            end
        end else begin
            prev_wait = 1'b0;
        end
    end

    task automatic push_job(input logic [15:0] s, input logic [15:0] d, input logic [7:0] n);
        logic [15:0] a, w;
        for (int i = 0; i < int'(n); i++) begin
            a = {s[15:1], 1'b0} + 16'(2 * i);
            w = {d[15:1], 1'b0} + 16'(2 * i);
            exp_q.push_back('{we: 2'b00, addr: a, data: 16'h0000});
            exp_q.push_back('{we: 2'b11, addr: w, data: pat(a)});
        end
    endtask

    // call at #1 after an edge; returns at #1 after the sampling edge
    task automatic start_job(input logic [15:0] s, input logic [15:0] d, input logic [7:0] n,
                             output int sc);
        cfg_src = s;
        cfg_dst = d;
        cfg_len = n;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        sc    = cyc;
    endtask

    task automatic wait_idle(input int limit);
        int k = 0;
        while (busy && k < limit) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (busy) check_val("timeout_busy", busy, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int sc, d0, e0;
        reset_n = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        cfg_src = '0;
        cfg_dst = '0;
        cfg_len = '0;
        idle_cycles(2);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_err", err, 0);
        check_val("rst_en", bus.dma_en, 0);
        check_val("rst_we", bus.dma_we, 0);
        check_val("rst_addr", bus.dma_addr, 0);
        check_val("rst_words", words_left, 0);
        reset_n = 1'b1;
        idle_cycles(1);

        // basic 3-word copy, ready always high
        d0 = done_cnt;
        push_job(16'h0200, 16'h0400, 8'd3);
        start_job(16'h0200, 16'h0400, 8'd3, sc);
        check_val("basic_busy", busy, 1);
        check_val("basic_words", words_left, 3);
        wait_idle(100);
        check_val("basic_latency", done_cyc - sc, 10);
        check_val("basic_done_cnt", done_cnt - d0, 1);
        check_val("basic_err", err, 0);
        check_val("basic_sb_empty", exp_q.size(), 0);
        check_val("basic_words_end", words_left, 0);

        // 4 wait cycles on first read
        d0 = done_cnt;
        wait_cnt = 0;
        stall = 4;
        push_job(16'h0300, 16'h0500, 8'd1);
        start_job(16'h0300, 16'h0500, 8'd1, sc);
        wait_idle(100);
        check_val("stall_waits", wait_cnt, 4);
        check_val("stall_latency", done_cyc - sc, 8);
        check_val("stall_sb_empty", exp_q.size(), 0);
        check_val("stall_done_cnt", done_cnt - d0, 1);

        // abort with ready in first WR cycle
        d0 = done_cnt;
        exp_q.push_back('{we: 2'b00, addr: 16'h0600, data: 16'h0000});
        start_job(16'h0600, 16'h0700, 8'd2, sc);
        idle_cycles(2);
        check_val("abort_in_wr", bus.dma_we, 2'b11);
        abort = 1'b1;
        idle_cycles(1);
        abort = 1'b0;
        check_val("abort_en", bus.dma_en, 0);
        check_val("abort_err", err, 1);
        check_val("abort_words", words_left, 2);
        check_val("abort_busy", busy, 0);
        idle_cycles(4);
        check_val("abort_no_done", done_cnt - d0, 0);
        check_val("abort_sb_empty", exp_q.size(), 0);

        // source wraps, destination with bit0 set
        d0 = done_cnt;
        push_job(16'hFFFE, 16'h0801, 8'd2);
        start_job(16'hFFFE, 16'h0801, 8'd2, sc);
        check_val("wrap_err_cleared", err, 0);
        wait_idle(100);
        check_val("wrap_latency", done_cyc - sc, 7);
        check_val("wrap_sb_empty", exp_q.size(), 0);
        check_val("wrap_err", err, 0);
        check_val("wrap_done_cnt", done_cnt - d0, 1);

        // error response on first read
        d0 = done_cnt;
        resp_once = 1'b1;
        start_job(16'h0900, 16'h0A00, 8'd2, sc);
        wait_idle(20);
        check_val("resp_err", err, 1);
        check_val("resp_no_done", done_cnt - d0, 0);
        check_val("resp_words", words_left, 2);
        push_job(16'h0B00, 16'h0C00, 8'd1);
        start_job(16'h0B00, 16'h0C00, 8'd1, sc);
        check_val("resp_err_clr", err, 0);
        wait_idle(100);
        check_val("resp_recover_done", done_cnt - d0, 1);
        check_val("resp_recover_sb", exp_q.size(), 0);

        // empty job
        d0 = done_cnt;
        e0 = en_cnt;
        start_job(16'h1000, 16'h2000, 8'd0, sc);
        wait_idle(20);
        check_val("len0_latency", done_cyc - sc, 1);
        check_val("len0_done_cnt", done_cnt - d0, 1);
        check_val("len0_no_en", en_cnt - e0, 0);

        // start while busy is ignored
        d0 = done_cnt;
        push_job(16'h0D00, 16'h0E00, 8'd2);
        start_job(16'h0D00, 16'h0E00, 8'd2, sc);
        idle_cycles(2);
        cfg_src = 16'h1234;
        cfg_dst = 16'h4320;
        cfg_len = 8'd5;
        start   = 1'b1;
        idle_cycles(1);
        start = 1'b0;
        wait_idle(100);
        check_val("busy_start_latency", done_cyc - sc, 7);
        check_val("busy_start_sb", exp_q.size(), 0);
        check_val("busy_start_words", words_left, 0);
        check_val("busy_start_done", done_cnt - d0, 1);

        // abort in IDLE, and abort together with start
        abort = 1'b1;
        idle_cycles(1);
        abort = 1'b0;
        check_val("idle_abort_err", err, 0);
        check_val("idle_abort_busy", busy, 0);
        e0 = en_cnt;
        cfg_len = 8'd1;
        start   = 1'b1;
        abort   = 1'b1;
        idle_cycles(1);
        start = 1'b0;
        abort = 1'b0;
        check_val("start_abort_busy", busy, 0);
        idle_cycles(3);
        check_val("start_abort_no_en", en_cnt - e0, 0);

        // reset in the middle of a job
        d0 = done_cnt;
        sb_en = 1'b0;
        start_job(16'h3000, 16'h4000, 8'd3, sc);
        idle_cycles(4);
        reset_n = 1'b0;
        idle_cycles(1);
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_en", bus.dma_en, 0);
        check_val("mid_rst_words", words_left, 0);
        reset_n = 1'b1;
        idle_cycles(5);
        check_val("mid_rst_no_done", done_cnt - d0, 0);
        exp_q.delete();
        sb_en = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
